fxp_mac_acc: RTL



---
 rtl/fxp_mac_acc_pkg.sv | 20 ++
 rtl/fxp_sat_add.sv | 21 ++
 rtl/fxp_mac_acc.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fxp_mac_acc_pkg.sv
// Shared types and saturation helpers for the fixed-point MAC datapath.
// Other accumulating stages (bias-add, pooling) reuse sat_add and the limits.
package fxp_mac_acc_pkg;

  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_e;

  localparam int SAT_W = 32;
  localparam logic [SAT_W-1:0] ACC_MAX = {1'b0, {(SAT_W-1){1'b1}}};
  localparam logic [SAT_W-1:0] ACC_MIN = {1'b1, {(SAT_W-1){1'b0}}};

  // Returns {ovf, sum}; sum is clamped when the true result leaves SAT_W range.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b);
    logic [SAT_W:0] s;
    s = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    if (s[SAT_W] != s[SAT_W-1]) return {1'b1, s[SAT_W] ? ACC_MIN : ACC_MAX};
    return {1'b0, s[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational W-bit signed saturating adder; ovf flags a clamped result.
module fxp_sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic [W:0] s;

  // One guard bit: top two bits disagree exactly when the signed range is exceeded.
  assign s     = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  assign ovf_o = s[W] ^ s[W-1];
  assign sum_o = ovf_o ? (s[W] ? MIN_V : MAX_V) : s[W-1:0];

endmodule

// File: rtl/fxp_mac_acc.sv
// Streaming signed fixed-point MAC for one neuron: NIN pairs in, one
// saturated ACC_W sum out with a sticky overflow flag.
module fxp_mac_acc
  import fxp_mac_acc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 32,
  parameter int NIN    = 16
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              busy
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = (NIN > 1) ? $clog2(NIN) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [PW-1:0] prod_q, mul;
  logic               p_valid_q, p_last_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;

  logic               xfer, last_term;
  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;

  assign in_ready  = reset_ && (state_q == ACC);
  assign xfer      = in_valid && in_ready;
  assign last_term = xfer && (cnt_q == CNT_W'(NIN - 1));
  assign mul       = PW'($signed(in_x)) * PW'($signed(in_w));
  assign prod_ext  = ACC_W'(prod_q);

  fxp_sat_add #(.W(ACC_W)) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      prod_q    <= '0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      p_valid_q <= xfer;
      p_last_q  <= last_term;
      if (xfer) prod_q <= mul;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (xfer) cnt_d = last_term ? '0 : cnt_q + CNT_W'(1);
    if (p_valid_q) begin
      acc_d = add_sum;
      ovf_d = ovf_q | add_ovf;
    end

    unique case (state_q)
      ACC:   if (last_term) state_d = DRAIN;
      DRAIN: if (p_valid_q && p_last_q) begin
        // Result register captures the sum that includes the final product.
        state_d     = DONE;
        out_valid_d = 1'b1;
        out_data_d  = add_sum;
        out_ovf_d   = ovf_q | add_ovf;
      end
      DONE:  if (out_ready) begin
        state_d     = ACC;
        out_valid_d = 1'b0;
        acc_d       = '0;
        ovf_d       = 1'b0;
      end
      default: state_d = ACC;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q != ACC) || (cnt_q != '0) || p_valid_q;

endmodule
